// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - fill/check bus initiator for the single-port valid/ready memory
//
// Writes data(a) = seed + a to every address, reads every address back and
// counts mismatches. Reports error count, first failing address and timeout.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i             begin a sequence (sampled only when idle)
//   mode_i              00 none, 01 write, 10 read-check, 11 write then read-check
//   seed_i              pattern seed
//   valid_o, wr_rd_o    request strobe and direction (1 = write)
//   addr_o, wr_data_o   request address and write data
//   rd_data_i, ready_i  read data and completion from memory
//   busy_o, done_o      sequence running / one-cycle completion pulse
//   err_o, err_cnt_o    mismatch flag and count
//   first_err_addr_o    address of the first mismatch
//   timeout_o           sequence aborted waiting for ready_i
module mem_initiator #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [WIDTH-1:0]      seed_i,
  output logic                  valid_o,
  output logic                  wr_rd_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wr_data_o,
  input  logic [WIDTH-1:0]      rd_data_i,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                  timeout_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      seed_q, seed_d;
  logic [1:0]            mode_q, mode_d;
  logic [TW-1:0]         wait_q, wait_d;
  logic [ADDR_WIDTH:0]   err_cnt_d;
  logic [ADDR_WIDTH-1:0] first_err_d;
  logic                  timeout_d;

  function automatic logic [WIDTH-1:0] pattern(input logic [WIDTH-1:0] s,
                                               input logic [ADDR_WIDTH-1:0] a);
    return s + WIDTH'(a);
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    seed_d      = seed_q;
    mode_d      = mode_q;
    wait_d      = wait_q;
    err_cnt_d   = err_cnt_o;
    first_err_d = first_err_addr_o;
    timeout_d   = timeout_o;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          seed_d      = seed_i;
          mode_d      = mode_i;
          addr_d      = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          timeout_d   = 1'b0;
          case (mode_i)
            2'b01, 2'b11: state_d = WR_REQ;
            2'b10:        state_d = RD_REQ;
            default:      state_d = DONE;
          endcase
        end
      end

      WR_REQ: begin
        state_d = WR_WAIT;
        wait_d  = '0;
      end

      WR_WAIT: begin
        if (ready_i) begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = (mode_q == 2'b11) ? RD_REQ : DONE;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = WR_REQ;
          end
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end

      RD_REQ: begin
        state_d = RD_WAIT;
        wait_d  = '0;
      end

      RD_WAIT: begin
        if (ready_i) begin
          if (rd_data_i != pattern(seed_q, addr_q)) begin
            err_cnt_d = err_cnt_o + (ADDR_WIDTH+1)'(1);
            if (err_cnt_o == '0) first_err_d = addr_q;
          end
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = RD_REQ;
          end
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      seed_q           <= '0;
      mode_q           <= '0;
      wait_q           <= '0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
      timeout_o        <= 1'b0;
      err_o            <= 1'b0;
      valid_o          <= 1'b0;
      wr_rd_o          <= 1'b0;
      addr_o           <= '0;
      wr_data_o        <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      seed_q           <= seed_d;
      mode_q           <= mode_d;
      wait_q           <= wait_d;
      err_cnt_o        <= err_cnt_d;
      first_err_addr_o <= first_err_d;
      timeout_o        <= timeout_d;
      err_o            <= (err_cnt_d != '0);
      valid_o          <= (state_d == WR_REQ) || (state_d == RD_REQ);
      wr_rd_o          <= (state_d == WR_REQ);
      addr_o           <= addr_d;
      wr_data_o        <= (state_d == WR_REQ) ? pattern(seed_d, addr_d) : '0;
      busy_o           <= (state_d != IDLE);
      done_o           <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - scoreboard bench for mem_initiator
module tb_mem_initiator;
  localparam int WIDTH = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [1:0]       mode_i;
  logic [WIDTH-1:0] seed_i;
  logic             valid_o, wr_rd_o;
  logic [AW-1:0]    addr_o;
  logic [WIDTH-1:0] wr_data_o;
  logic [WIDTH-1:0] rd_data_i = '0;
  logic             ready_i = 1'b0;
  logic             busy_o, done_o, err_o, timeout_o;
  logic [AW:0]      err_cnt_o;
  logic [AW-1:0]    first_err_addr_o;

  always #5 clk = ~clk;

  mem_initiator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .seed_i(seed_i),
    .valid_o(valid_o), .wr_rd_o(wr_rd_o), .addr_o(addr_o), .wr_data_o(wr_data_o),
    .rd_data_i(rd_data_i), .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o),
    .timeout_o(timeout_o)
  );

  // Memory model: ready the cycle after valid; mem_en=0 never answers.
  logic [WIDTH-1:0] mem_arr [DEPTH];
  logic             mem_en = 1'b1;
  logic             poke_en = 1'b0;
  logic [AW-1:0]    poke_addr = '0;
  logic [WIDTH-1:0] poke_data = '0;

  always @(posedge clk) begin
    ready_i <= 1'b0;
    if (poke_en) mem_arr[poke_addr] <= poke_data;
    if (valid_o && mem_en) begin
      if (wr_rd_o) mem_arr[addr_o] <= wr_data_o;
      else         rd_data_i <= mem_arr[addr_o];
      ready_i <= 1'b1;
    end
  end

  typedef struct {
    logic             wr;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } tx_t;

  typedef struct {
    int   cnt;
    int   first;
    logic to;
    int   lat;
  } res_t;

  tx_t  exp_tx[$];
  res_t exp_res[$];
  tx_t  cur_tx;
  res_t cur_res;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a request or completion.
  always @(negedge clk) begin
    if (valid_o) begin
      if (exp_tx.size() == 0) begin
        check("unexpected_valid", 32'(addr_o), 32'hFFFF_FFFF);
      end else begin
        cur_tx = exp_tx.pop_front();
        check("tx_wr_rd", 32'(wr_rd_o), 32'(cur_tx.wr));
        check("tx_addr", 32'(addr_o), 32'(cur_tx.addr));
        check("tx_wr_data", 32'(wr_data_o), 32'(cur_tx.data));
      end
    end
    if (done_o) begin
      if (exp_res.size() == 0) begin
        check("unexpected_done", 32'(done_o), 32'd0);
      end else begin
        cur_res = exp_res.pop_front();
        check("err_cnt", 32'(err_cnt_o), 32'(cur_res.cnt));
        check("first_err_addr", 32'(first_err_addr_o), 32'(cur_res.first));
        check("timeout", 32'(timeout_o), 32'(cur_res.to));
        check("err_flag", 32'(err_o), 32'(cur_res.cnt != 0));
        check("busy_in_done", 32'(busy_o), 32'd1);
        check("done_latency", 32'(cyc - start_cyc), 32'(cur_res.lat));
      end
    end
  end

  task automatic push_fill(input logic wr, input logic [WIDTH-1:0] seed, input int last);
    tx_t t;
    for (int a = 0; a <= last; a++) begin
      t.wr   = wr;
      t.addr = AW'(a);
      t.data = wr ? seed + WIDTH'(a) : '0;
      exp_tx.push_back(t);
    end
  endtask

  task automatic push_res(input int cnt, input int first, input logic to, input int lat);
    res_t r;
    r.cnt = cnt; r.first = first; r.to = to; r.lat = lat;
    exp_res.push_back(r);
  endtask

  // Start is sampled at the posedge after this negedge; that edge is cycle E0.
  task automatic run(input logic [1:0] mode, input logic [WIDTH-1:0] seed);
    @(negedge clk);
    start_i   = 1'b1;
    mode_i    = mode;
    seed_i    = seed;
    start_cyc = cyc + 1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    check({name, "_idle_busy"}, 32'(busy_o), 32'd0);
    check({name, "_idle_done"}, 32'(done_o), 32'd0);
    check({name, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
    check({name, "_res_left"}, 32'(exp_res.size()), 32'd0);
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  initial begin
    bit hit;
    rst = 1'b1; start_i = 1'b1; mode_i = 2'b11; seed_i = 16'h1234;

    // Reset held with start asserted: everything stays zero.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_outs", 32'({done_o, err_o, timeout_o, wr_rd_o, err_cnt_o, first_err_addr_o, addr_o}), 32'd0);
      check("rst_wr_data", 32'(wr_data_o), 32'd0);
    end
    start_i = 1'b0;
    rst = 1'b0;

    // Clean fill/check, mode 11.
    push_fill(1'b1, 16'h1000, DEPTH-1);
    push_fill(1'b0, 16'h1000, DEPTH-1);
    push_res(0, 0, 1'b0, 256);
    run(2'b11, 16'h1000);
    wait_done("clean");

    // Corrupt two words, then read-check only.
    poke(6'd5, 16'hDEAD);
    poke(6'd40, 16'h0000);
    push_fill(1'b0, 16'h1000, DEPTH-1);
    push_res(2, 5, 1'b0, 128);
    run(2'b10, 16'h1000);
    wait_done("errdet");

    // Memory never answers: one request, then abort after 16 wait cycles.
    mem_en = 1'b0;
    push_fill(1'b1, 16'h2222, 0);
    push_res(0, 0, 1'b1, 17);
    run(2'b01, 16'h2222);
    wait_done("timeout");
    mem_en = 1'b1;

    // Seed 0xFFFF wraps data; a start pulse mid-sequence is ignored.
    push_fill(1'b1, 16'hFFFF, DEPTH-1);
    push_res(0, 0, 1'b0, 128);
    run(2'b01, 16'hFFFF);
    repeat (7) @(negedge clk);
    start_i = 1'b1; mode_i = 2'b10; seed_i = 16'h1234;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("wrap_busy");

    // Mode 00: done the cycle after start, no requests.
    push_res(0, 0, 1'b0, 0);
    run(2'b00, 16'h0000);
    wait_done("mode00");

    // Reset during the write request of address 10.
    push_fill(1'b1, 16'h5555, 10);
    run(2'b01, 16'h5555);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (valid_o && addr_o == 6'd10) hit = 1;
    end
    check("midrst_reached", 32'(hit), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_tx_left", 32'(exp_tx.size()), 32'd0);
    rst = 1'b0;
    push_fill(1'b1, 16'h0000, DEPTH-1);
    push_res(0, 0, 1'b0, 128);
    run(2'b01, 16'h0000);
    wait_done("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
